// File: rtl/digit_pkg.sv
// digit_pkg: default geometry of the digit entry buffer and its command priority encoding.
package digit_pkg;
    localparam int DEF_DIGIT_W    = 4;
    localparam int DEF_NUM_DIGITS = 4;
    localparam int DEF_MAX_VAL    = 9;

    // Ordered from highest to lowest priority; only one command acts per cycle.
    typedef enum logic [2:0] {
        CMD_NONE = 3'd0,
        CMD_CLR  = 3'd1,
        CMD_BKSP = 3'd2,
        CMD_PUSH = 3'd3,
        CMD_SEL  = 3'd4
    } cmd_t;
endpackage

// File: rtl/digit_slot.sv
// digit_slot: one digit register with synchronous active-low reset and load enable.
module digit_slot #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (!rst)
            q <= '0;
        else if (ld)
            q <= d;
    end
endmodule

// File: rtl/digit_entry_buffer.sv
// digit_entry_buffer: keypad-style digit shift buffer with push, backspace, clear and direct slot writes.
module digit_entry_buffer
    import digit_pkg::*;
#(
    parameter int DIGIT_W    = DEF_DIGIT_W,
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int MAX_VAL    = DEF_MAX_VAL
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DIGIT_W-1:0]              digit,
    input  logic                            push,
    input  logic                            bksp,
    input  logic                            clr,
    input  logic [NUM_DIGITS-1:0]           sel,
    output logic [NUM_DIGITS*DIGIT_W-1:0]   digits_out,
    output logic [$clog2(NUM_DIGITS+1)-1:0] count,
    output logic                            full,
    output logic                            err
);
    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam logic [DIGIT_W-1:0] MAX_D = DIGIT_W'(MAX_VAL);

    cmd_t cmd;
    logic bad, multi, rej, go_clr, go_bksp, go_push, go_sel;
    logic [DIGIT_W-1:0] q [NUM_DIGITS];

    assign full  = count == CW'(NUM_DIGITS);
    assign bad   = digit > MAX_D;
    assign multi = |(sel & (sel - NUM_DIGITS'(1)));

    always_comb begin
        cmd = clr ? CMD_CLR : bksp ? CMD_BKSP : push ? CMD_PUSH : |sel ? CMD_SEL : CMD_NONE;
        rej = (cmd == CMD_BKSP && count == '0) ||
              (cmd == CMD_PUSH && (full || bad)) ||
              (cmd == CMD_SEL && (multi || bad));
        go_clr  = cmd == CMD_CLR;
        go_bksp = cmd == CMD_BKSP && !rej;
        go_push = cmd == CMD_PUSH && !rej;
        go_sel  = cmd == CMD_SEL && !rej;
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_slot
        logic [DIGIT_W-1:0] above, below, d;
        logic ld;
        if (k == NUM_DIGITS - 1) begin : g_top
            assign above = '0;
        end else begin : g_mid
            assign above = q[k+1];
        end
        if (k == 0) begin : g_bot
            assign below = digit;
        end else begin : g_up
            assign below = q[k-1];
        end
        assign ld = go_clr | go_bksp | go_push | (go_sel & sel[k]);
        assign d  = go_clr ? '0 : go_bksp ? above : go_push ? below : digit;
        digit_slot #(.W(DIGIT_W)) u_slot (
            .clk(clk),
            .rst(rst),
            .ld (ld),
            .d  (d),
            .q  (q[k])
        );
        assign digits_out[k*DIGIT_W +: DIGIT_W] = q[k];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
            err   <= 1'b0;
        end else begin
            err   <= rej;
            count <= go_clr ? '0 : go_bksp ? count - CW'(1) : go_push ? count + CW'(1) : count;
        end
    end
endmodule

// File: tb/tb_digit_entry_buffer.sv
// tb_digit_entry_buffer: randomized scoreboard bench against an array-based model of the entry buffer.
module tb_digit_entry_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  digit = '0;
    logic        push = 1'b0, bksp = 1'b0, clr = 1'b0;
    logic [3:0]  sel = '0;
    logic [15:0] digits_out;
    logic [2:0]  count;
    logic        full, err;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] d;
        logic [2:0]  c;
        logic        f;
        logic        e;
    } exp_t;

    exp_t sb[$];
    int   m[4];
    int   mc;

    digit_entry_buffer dut (
        .clk(clk), .rst(rst), .digit(digit), .push(push), .bksp(bksp), .clr(clr),
        .sel(sel), .digits_out(digits_out), .count(count), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic c, input logic b, input logic p,
                        input logic [3:0] s, input logic [3:0] dv);
        exp_t x;
        logic e;
        @(negedge clk);
        rst = r; clr = c; bksp = b; push = p; sel = s; digit = dv;
        e = 1'b0;
        if (!r || c) begin
            for (int i = 0; i < 4; i++) m[i] = 0;
            mc = 0;
        end else if (b) begin
            if (mc == 0) e = 1'b1;
            else begin
                for (int i = 0; i < 3; i++) m[i] = m[i+1];
                m[3] = 0;
                mc--;
            end
        end else if (p) begin
            if (mc == 4 || dv > 9) e = 1'b1;
            else begin
                for (int i = 3; i > 0; i--) m[i] = m[i-1];
                m[0] = int'(dv);
                mc++;
            end
        end else if (s != 0) begin
            if ($countones(s) > 1 || dv > 9) e = 1'b1;
            else for (int i = 0; i < 4; i++) if (s[i]) m[i] = int'(dv);
        end
        x.d = '0;
        for (int i = 0; i < 4; i++) x.d = x.d | (16'(m[i]) << (4 * i));
        x.c = 3'(mc);
        x.f = mc == 4;
        x.e = e;
        sb.push_back(x);
    endtask

    task automatic expect_now(input string name, input logic [15:0] d, input logic [2:0] c,
                              input logic f, input logic e);
        @(posedge clk);
        #2;
        checks++;
        if (digits_out !== d || count !== c || full !== f || err !== e) begin
            failures++;
            $display("FAIL %s: got digits=%h count=%0d full=%b err=%b, want digits=%h count=%0d full=%b err=%b",
                     name, digits_out, count, full, err, d, c, f, e);
        end
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                checks++;
                if (digits_out !== x.d || count !== x.c || full !== x.f || err !== x.e) begin
                    failures++;
                    $display("FAIL scoreboard @%0t: got digits=%h count=%0d full=%b err=%b, want digits=%h count=%0d full=%b err=%b",
                             $time, digits_out, count, full, err, x.d, x.c, x.f, x.e);
                end
            end
        end
    end

    initial begin : driver
        logic [3:0] s, dv;
        int op;
        for (int i = 0; i < 4; i++) m[i] = 0;
        mc = 0;
        step(0, 0, 0, 0, 4'b0000, 4'd0);
        step(0, 1, 0, 1, 4'b0000, 4'd3);
        expect_now("reset", 16'h0000, 3'd0, 1'b0, 1'b0);
        step(1, 0, 0, 1, 4'b0000, 4'd1);
        step(1, 0, 0, 1, 4'b0000, 4'd2);
        step(1, 0, 0, 1, 4'b0000, 4'd3);
        expect_now("push_123", 16'h0123, 3'd3, 1'b0, 1'b0);
        step(1, 1, 0, 0, 4'b0000, 4'd0);
        for (int i = 1; i <= 4; i++) step(1, 0, 0, 1, 4'b0000, 4'(i));
        expect_now("push_full", 16'h1234, 3'd4, 1'b1, 1'b0);
        step(1, 0, 0, 1, 4'b0000, 4'd5);
        expect_now("push_overflow", 16'h1234, 3'd4, 1'b1, 1'b1);
        step(1, 0, 0, 0, 4'b0000, 4'd0);
        expect_now("err_one_cycle", 16'h1234, 3'd4, 1'b1, 1'b0);
        step(1, 0, 1, 0, 4'b0000, 4'd0);
        expect_now("bksp_1", 16'h0123, 3'd3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 4'b0000, 4'd0);
        expect_now("bksp_empty", 16'h0000, 3'd0, 1'b0, 1'b0);
        step(1, 0, 1, 0, 4'b0000, 4'd0);
        expect_now("bksp_underflow", 16'h0000, 3'd0, 1'b0, 1'b1);
        step(1, 0, 0, 1, 4'b0000, 4'hA);
        expect_now("push_bad_digit", 16'h0000, 3'd0, 1'b0, 1'b1);
        for (int i = 1; i <= 3; i++) step(1, 0, 0, 1, 4'b0000, 4'(i));
        step(1, 1, 0, 1, 4'b0001, 4'd5);
        expect_now("clr_priority", 16'h0000, 3'd0, 1'b0, 1'b0);
        step(1, 0, 0, 0, 4'b0100, 4'd7);
        expect_now("sel_write", 16'h0700, 3'd0, 1'b0, 1'b0);
        step(1, 0, 0, 0, 4'b0110, 4'd3);
        expect_now("sel_multi", 16'h0700, 3'd0, 1'b0, 1'b1);
        step(1, 0, 0, 1, 4'b0000, 4'd1);
        step(0, 0, 0, 1, 4'b0000, 4'd2);
        expect_now("reset_mid", 16'h0000, 3'd0, 1'b0, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            op = $urandom_range(0, 99);
            dv = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            s  = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
            if (op < 2)       step(0, 1'($urandom), 1'($urandom), 1'($urandom), s, dv);
            else if (op < 6)  step(1, 1, 1'($urandom), 1'($urandom), s, dv);
            else if (op < 30) step(1, 0, 1, 1'($urandom), 4'($urandom), dv);
            else if (op < 65) step(1, 0, 0, 1, 4'($urandom), dv);
            else if (op < 90) step(1, 0, 0, 0, s, dv);
            else              step(1, 0, 0, 0, 4'b0000, dv);
        end
        step(1, 0, 0, 0, 4'b0000, 4'd0);
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
        #3;
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expected responses never checked, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
